reuleaux_sched: RTL and testbench
=================================

// Module: reuleaux_sched
// PURPOSE
//  Sequencer for the three circle-segment engines (SEGMENT_TYPE 1/2/3) that together draw one Reuleaux triangle.
//  Computes the three arc centres from the triangle centre and diameter, then starts each engine in turn.
//  Muxes each engine's VGA output onto the single framebuffer write port and returns one done to the top level.
// PARAMETERS
//  SQRT3_6_Q8  74   sqrt(3)/6 in Q8 (0.2887*256), used for centre offsets
//  SCR_W       160  screen width in pixels (clear sweep, x 0..159)
//  SCR_H       120  screen height in pixels (clear sweep, y 0..119)
// PORTS
//  clk          in   1      single clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      level request; held high by requester until done
//  centre_x     in   10s    triangle centre x, signed
//  centre_y     in   9s     triangle centre y, signed
//  diameter     in   9s     triangle diameter (= arc radius), signed, >0
//  colour       in   3      drawing colour
//  done         out  1      high from completion until start deasserts
//  c_start      out  3      per-engine start, bit i -> engine i+1
//  c_done       in   3      per-engine done
//  c_cx         out  3x10s  per-engine centre x (packed [29:0], engine 1 in [9:0])
//  c_cy         out  3x9s   per-engine centre y (packed [26:0])
//  c_radius     out  9s     common radius = diameter
//  c_vga_x      in   3x8    engine pixel x (packed)
//  c_vga_y      in   3x7    engine pixel y (packed)
//  c_plot       in   3      engine plot strobes
//  vga_x        out  8      framebuffer x
//  vga_y        out  7      framebuffer y
//  vga_colour   out  3      framebuffer colour
//  vga_plot     out  1      framebuffer write strobe
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; done, c_start, vga_plot=0; vga_x/y/colour=0; centre regs=0.
//  - IDLE: wait for start=1. On that edge, latch centre_x/centre_y/diameter/colour into registers -> CALC.
//  - CALC (1 cycle):
//    - off = (diameter*SQRT3_6_Q8)>>>8, computed in 19-bit signed with arithmetic shift.
//    - half = diameter>>>1.
//    - c1 = (cx+half, cy+off); c2 = (cx-half, cy+off); c3 = (cx, cy-2*off).
//    - Results truncate to port widths; no saturation.
//  - RUNn (n=1..3): c_start[n-1]=1, all other bits 0.
//    - vga_x/y/plot are passed combinationally from engine n; vga_colour=colour latch.
//    - Other engines' plot strobes are ignored.
//  - c_done[n-1]=1 in RUNn -> DROPn: c_start[n-1]=0, vga_plot=0.
//    - Wait for c_done[n-1]=0, then -> RUN(n+1), or from DROP3 -> FIN.
//  - FIN: done=1; hold until start=0 -> IDLE (done falls the same cycle).
//  - start dropped mid-run: ignored; sequence completes, then FIN exits immediately.
//  - c_done already high on entry to RUNn: treated as complete -> DROPn after 1 cycle with no pixels.
//  - At most one c_start bit is high in any cycle.
//  - vga_plot is 0 in IDLE/CALC/DROPn/FIN.
//  - Latency start->first engine start: 2 cycles (latch, CALC).
// CONFIGURATION
//  - REULEAUX_CLEAR_EN defined: CALC -> CLEAR instead of RUN1.
//    - Raster sweep y outer 0..SCR_H-1, x inner 0..SCR_W-1; vga_plot=1, colour=3'b000.
//    - One pixel per cycle; 19200 cycles. After (159,119) -> RUN1.
//  - REULEAUX_CLEAR_EN undefined: no CLEAR state, no clear counters; CALC -> RUN1.
// STRUCTURE
//  - reuleaux_pkg:
//    - state enum (IDLE, CALC, CLEAR, RUN1..3, DROP1..3, FIN).
//    - SQRT3_6_Q8, SCR_W, SCR_H.
//    - Engine index localparams.
//  - Sub-module reuleaux_centres: registered centre arithmetic; load strobe in CALC, outputs c_cx/c_cy.
//  - Engine instances are outside this block; reuleaux_sched only drives and observes them.
// TESTING
//  - Centres: cx=80, cy=60, d=80 -> off=23.
//    - c1=(120,83), c2=(40,83), c3=(80,14); c_radius=80.
//  - Ordering with model engines (done 5 cycles after start): c_start pulses 001,010,100 in order, never overlapping.
//    - Model engines hold done while start=1.
//    - done rises after DROP3; done falls one cycle after start=0.
//  - Mux: engine 2 plots (10,20) while engine 1 strobes spuriously.
//    - vga_plot/x/y reflect engine 2 only; colour=latched 3'b010.
//  - Async reset asserted in RUN2: all outputs 0 immediately, c_start=000.
//    - After release, a new start restarts at engine 1.
//  - start low mid-RUN1: sequence still completes; done pulses 1 cycle in FIN, then IDLE.
//  - REULEAUX_CLEAR_EN: 19200 black plots, last at (159,119), then c_start=001.
//    - Without the macro, c_start=001 two cycles after start.

Source files
------------

// File: rtl/reuleaux_pkg.sv
// Shared definitions for the Reuleaux triangle sequencer.
//   state_e     : sequencer states
//   SQRT3_6_Q8  : sqrt(3)/6 in Q8, scales diameter into the vertical arc-centre offset
//   SCR_W/SCR_H : screen size swept by the optional clear pass
//   ENGn        : bit / lane index of engine n in the packed engine buses
//   run_engine  : maps a RUNn state to its engine lane, ENG_NONE otherwise
package reuleaux_pkg;

    typedef enum logic [3:0] {
        IDLE, CALC, CLEAR, RUN1, RUN2, RUN3, DROP1, DROP2, DROP3, FIN
    } state_e;

    localparam int SQRT3_6_Q8 = 74;
    localparam int SCR_W      = 160;
    localparam int SCR_H      = 120;

    localparam int ENG1     = 0;
    localparam int ENG2     = 1;
    localparam int ENG3     = 2;
    localparam int ENG_NONE = 3;

    function automatic logic [1:0] run_engine(input state_e s);
        case (s)
            RUN1:    return 2'(ENG1);
            RUN2:    return 2'(ENG2);
            RUN3:    return 2'(ENG3);
            default: return 2'(ENG_NONE);
        endcase
    endfunction

endpackage

// File: rtl/reuleaux_centres.sv
// Registered arc-centre arithmetic for the three circle-segment engines.
//   clk, rst_n : clock, async active-low reset (centres clear to 0)
//   load       : capture new centres this cycle
//   cx, cy     : triangle centre (signed)
//   diameter   : triangle diameter (signed)
//   c_cx       : packed engine centre x, engine 1 in [9:0]
//   c_cy       : packed engine centre y, engine 1 in [8:0]
// All sums are formed in 19-bit signed and truncated to port widths.
module reuleaux_centres
    import reuleaux_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic signed [9:0]  cx,
    input  logic signed [8:0]  cy,
    input  logic signed [8:0]  diameter,
    output logic        [29:0] c_cx,
    output logic        [26:0] c_cy
);

    logic signed [18:0] d_ext;
    logic signed [18:0] cx_ext;
    logic signed [18:0] cy_ext;
    logic signed [18:0] prod;
    logic signed [18:0] off;
    logic signed [18:0] half;
    logic        [29:0] c_cx_d, c_cx_q;
    logic        [26:0] c_cy_d, c_cy_q;

    always_comb begin
        d_ext  = {{10{diameter[8]}}, diameter};
        cx_ext = {{9{cx[9]}}, cx};
        cy_ext = {{10{cy[8]}}, cy};
        prod   = d_ext * $signed(19'(SQRT3_6_Q8));
        off    = prod >>> 8;
        half   = d_ext >>> 1;
        c_cx_d = {cx, 10'(cx_ext - half), 10'(cx_ext + half)};
        c_cy_d = {9'(cy_ext - (off <<< 1)), 9'(cy_ext + off), 9'(cy_ext + off)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cx_q <= '0;
            c_cy_q <= '0;
        end else if (load) begin
            c_cx_q <= c_cx_d;
            c_cy_q <= c_cy_d;
        end
    end

    assign c_cx = c_cx_q;
    assign c_cy = c_cy_q;

endmodule

// File: rtl/reuleaux_sched.sv
// Sequencer that draws one Reuleaux triangle with three circle-segment engines.
// Latches the request, computes arc centres, starts engines 1..3 in turn and
// muxes the active engine onto the framebuffer write port.
//   clk, rst_n          : clock, async active-low reset
//   start / done        : level request / completion handshake
//   centre_x/y, diameter, colour : drawing request
//   c_start, c_done     : per-engine start/done (bit i -> engine i+1)
//   c_cx, c_cy, c_radius: per-engine centres and common radius
//   c_vga_x/y, c_plot   : per-engine pixel outputs
//   vga_x/y/colour/plot : framebuffer write port
// Build option: REULEAUX_CLEAR_EN inserts a black full-screen clear before engine 1.
//
// state | meaning
// IDLE  | waiting for start, request latched on exit
// CALC  | centres computed and registered
// CLEAR | raster sweep writing black (REULEAUX_CLEAR_EN only)
// RUNn  | engine n started, its pixels routed to the framebuffer
// DROPn | engine n start withdrawn, waiting for its done to fall
// FIN   | done high until start is released
module reuleaux_sched
    import reuleaux_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [9:0]  centre_x,
    input  logic signed [8:0]  centre_y,
    input  logic signed [8:0]  diameter,
    input  logic        [2:0]  colour,
    output logic               done,
    output logic        [2:0]  c_start,
    input  logic        [2:0]  c_done,
    output logic        [29:0] c_cx,
    output logic        [26:0] c_cy,
    output logic signed [8:0]  c_radius,
    input  logic        [23:0] c_vga_x,
    input  logic        [20:0] c_vga_y,
    input  logic        [2:0]  c_plot,
    output logic        [7:0]  vga_x,
    output logic        [6:0]  vga_y,
    output logic        [2:0]  vga_colour,
    output logic               vga_plot
);

    state_e             state_q, state_d;
    logic signed [9:0]  cx_q, cx_d;
    logic signed [8:0]  cy_q, cy_d;
    logic signed [8:0]  dia_q, dia_d;
    logic        [2:0]  colour_q, colour_d;
    logic        [2:0]  c_start_q, c_start_d;
    logic               done_q, done_d;
    logic        [1:0]  eng;
`ifdef REULEAUX_CLEAR_EN
    logic        [7:0]  clr_x_q, clr_x_d;
    logic        [6:0]  clr_y_q, clr_y_d;
`endif

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        dia_d     = dia_q;
        colour_d  = colour_q;
        c_start_d = c_start_q;
        done_d    = done_q;
`ifdef REULEAUX_CLEAR_EN
        clr_x_d   = clr_x_q;
        clr_y_d   = clr_y_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                cx_d     = centre_x;
                cy_d     = centre_y;
                dia_d    = diameter;
                colour_d = colour;
                state_d  = CALC;
            end
`ifdef REULEAUX_CLEAR_EN
            CALC: begin
                clr_x_d = '0;
                clr_y_d = '0;
                state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_x_q == 8'(SCR_W - 1)) begin
                    clr_x_d = '0;
                    if (clr_y_q == 7'(SCR_H - 1)) begin
                        clr_y_d   = '0;
                        c_start_d = 3'b001;
                        state_d   = RUN1;
                    end else begin
                        clr_y_d = clr_y_q + 7'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 8'd1;
                end
            end
`else
            CALC: begin
                c_start_d = 3'b001;
                state_d   = RUN1;
            end
`endif
            RUN1:  if (c_done[ENG1])  begin c_start_d = 3'b000; state_d = DROP1; end
            DROP1: if (!c_done[ENG1]) begin c_start_d = 3'b010; state_d = RUN2;  end
            RUN2:  if (c_done[ENG2])  begin c_start_d = 3'b000; state_d = DROP2; end
            DROP2: if (!c_done[ENG2]) begin c_start_d = 3'b100; state_d = RUN3;  end
            RUN3:  if (c_done[ENG3])  begin c_start_d = 3'b000; state_d = DROP3; end
            DROP3: if (!c_done[ENG3]) begin done_d    = 1'b1;   state_d = FIN;   end
            FIN:   if (!start)        begin done_d    = 1'b0;   state_d = IDLE;  end
            default: begin
                c_start_d = 3'b000;
                done_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            dia_q     <= '0;
            colour_q  <= '0;
            c_start_q <= '0;
            done_q    <= 1'b0;
`ifdef REULEAUX_CLEAR_EN
            clr_x_q   <= '0;
            clr_y_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            dia_q     <= dia_d;
            colour_q  <= colour_d;
            c_start_q <= c_start_d;
            done_q    <= done_d;
`ifdef REULEAUX_CLEAR_EN
            clr_x_q   <= clr_x_d;
            clr_y_q   <= clr_y_d;
`endif
        end
    end

    reuleaux_centres u_centres (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == CALC),
        .cx       (cx_q),
        .cy       (cy_q),
        .diameter (dia_q),
        .c_cx     (c_cx),
        .c_cy     (c_cy)
    );

    // Pixel path is combinational so engine pixels reach the framebuffer
    // in the same cycle; only the active engine's strobe is honoured.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        eng        = run_engine(state_q);
        if (eng != 2'(ENG_NONE)) begin
            vga_x      = c_vga_x[8*eng +: 8];
            vga_y      = c_vga_y[7*eng +: 7];
            vga_plot   = c_plot[eng];
            vga_colour = colour_q;
        end
`ifdef REULEAUX_CLEAR_EN
        if (state_q == CLEAR) begin
            vga_x    = clr_x_q;
            vga_y    = clr_y_q;
            vga_plot = 1'b1;
        end
`endif
    end

    assign c_start  = c_start_q;
    assign done     = done_q;
    assign c_radius = dia_q;

endmodule

// File: tb/tb_reuleaux_sched.sv
module tb_reuleaux_sched;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [9:0]  centre_x;
    logic signed [8:0]  centre_y;
    logic signed [8:0]  diameter;
    logic        [2:0]  colour;
    logic               done;
    logic        [2:0]  c_start;
    logic        [2:0]  c_done;
    logic        [29:0] c_cx;
    logic        [26:0] c_cy;
    logic signed [8:0]  c_radius;
    logic        [23:0] c_vga_x;
    logic        [20:0] c_vga_y;
    logic        [2:0]  c_plot;
    logic        [7:0]  vga_x;
    logic        [6:0]  vga_y;
    logic        [2:0]  vga_colour;
    logic               vga_plot;

    int vectors = 0;
    int miscompares = 0;

    logic       auto_eng = 1'b0;
    logic [2:0] man_done = 3'b000;
    logic [2:0] mdone = 3'b000;
    int         mcnt [3] = '{0, 0, 0};

`ifdef REULEAUX_CLEAR_EN
    localparam int EXP_LAT   = 19202;
    localparam int EXP_PLOTS = 19200;
`else
    localparam int EXP_LAT   = 2;
    localparam int EXP_PLOTS = 0;
`endif

    always #5 clk = ~clk;

    assign c_done = auto_eng ? mdone : man_done;

    // Model engines: done 5 cycles after start, held while start stays high.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (c_start[i]) begin
                if (mcnt[i] == 4) mdone[i] <= 1'b1;
                else mcnt[i] <= mcnt[i] + 1;
            end else begin
                mcnt[i]  <= 0;
                mdone[i] <= 1'b0;
            end
        end
    end

    reuleaux_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .diameter   (diameter),
        .colour     (colour),
        .done       (done),
        .c_start    (c_start),
        .c_done     (c_done),
        .c_cx       (c_cx),
        .c_cy       (c_cy),
        .c_radius   (c_radius),
        .c_vga_x    (c_vga_x),
        .c_vga_y    (c_vga_y),
        .c_plot     (c_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts negedges from now until c_start==001, and black plots on the way.
    task automatic wait_run1(output int lat, output int plots, output int lx, output int ly);
        lat = 0; plots = 0; lx = -1; ly = -1;
        while (lat < 20000) begin
            @(negedge clk);
            lat++;
            if (c_start == 3'b001) break;
            if (vga_plot && vga_colour == 3'b000) begin
                plots++; lx = int'(vga_x); ly = int'(vga_y);
            end
        end
    endtask

    initial begin
        int lat, plots, lx, ly, n, nseq, overlap;
        logic [2:0] seq [4];
        logic [2:0] prev;

        rst_n = 1'b0; start = 1'b0;
        centre_x = 10'sd80; centre_y = 9'sd60; diameter = 9'sd80; colour = 3'b010;
        c_vga_x = '0; c_vga_y = '0; c_plot = '0;
        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_c_start", c_start, 0);
        check("rst_vga_plot", vga_plot, 0);
        check("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
        check("rst_c_cx", c_cx, 0);
        check("rst_c_cy", c_cy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Centre computation and start latency.
        start = 1'b1;
        wait_run1(lat, plots, lx, ly);
        check("latency_run1", lat, EXP_LAT);
        check("clear_plots", plots, EXP_PLOTS);
`ifdef REULEAUX_CLEAR_EN
        check("clear_last_x", lx, 159);
        check("clear_last_y", ly, 119);
`endif
        check("c1_x", c_cx[9:0], 120);
        check("c2_x", c_cx[19:10], 40);
        check("c3_x", c_cx[29:20], 80);
        check("c1_y", c_cy[8:0], 83);
        check("c2_y", c_cy[17:9], 83);
        check("c3_y", c_cy[26:18], 14);
        check("c_radius", c_radius, 80);

        // Mux: engine 1 done, then engine 2 plots while engine 1 strobes spuriously.
        man_done = 3'b001; c_plot = 3'b001;
        @(negedge clk);
        check("drop1_c_start", c_start, 0);
        check("drop1_plot", vga_plot, 0);
        man_done = 3'b000;
        @(negedge clk);
        check("run2_c_start", c_start, 3'b010);
        c_vga_x = {8'd0, 8'd10, 8'd99};
        c_vga_y = {7'd0, 7'd20, 7'd55};
        c_plot  = 3'b011;
        #1;
        check("mux_plot", vga_plot, 1);
        check("mux_x", vga_x, 10);
        check("mux_y", vga_y, 20);
        check("mux_colour", vga_colour, 3'b010);
        c_plot = 3'b001;
        #1;
        check("mux_spurious", vga_plot, 0);

        // Async reset in RUN2.
        c_plot = 3'b010;
        #1 rst_n = 1'b0;
        #1;
        check("arst_c_start", c_start, 0);
        check("arst_plot", vga_plot, 0);
        check("arst_vga", {vga_x, vga_y, vga_colour}, 0);
        check("arst_done", done, 0);
        check("arst_c_cx", c_cx, 0);
        start = 1'b0; c_plot = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        auto_eng = 1'b1;
        @(negedge clk);
        start = 1'b1;
        wait_run1(lat, plots, lx, ly);
        check("restart_run1", lat, EXP_LAT);

        // Ordering with model engines.
        nseq = 1; seq[0] = 3'b001; prev = 3'b001; overlap = 0; n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if ($countones(c_start) > 1) overlap++;
            if (c_start != prev && c_start != 3'b000 && nseq < 4) begin
                seq[nseq] = c_start; nseq++;
            end
            prev = c_start;
        end
        check("order_done", done, 1);
        check("order_count", nseq, 3);
        check("order_e2", seq[1], 3'b010);
        check("order_e3", seq[2], 3'b100);
        check("order_overlap", overlap, 0);
        check("fin_c_start", c_start, 0);
        @(negedge clk);
        check("fin_hold", done, 1);
        start = 1'b0;
        @(negedge clk);
        check("fin_release", done, 0);

        // start dropped mid-RUN1.
        start = 1'b1;
        wait_run1(lat, plots, lx, ly);
        check("midrun_run1", lat, EXP_LAT);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrun_done", done, 1);
        @(negedge clk);
        check("midrun_pulse", done, 0);
        @(negedge clk);
        check("midrun_idle", {done, c_start}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
